// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with request/ack handshake
package seg_scan_pkg;
  typedef enum logic {MODE_DONE = 1'b0, MODE_START = 1'b1} mode_t;
endpackage

module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int          NDIG   = 4,
  parameter int          DWELL  = 4,
  parameter int          FRAMES = 2,
  parameter logic [6:0]  ESEG   = 7'b1111100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [4*NDIG-1:0] data_in,
  output logic              ack,
  output mode_t             mode,
  output logic              done_p,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   dig_en
);

  localparam int WW   = (DWELL  > 1) ? $clog2(DWELL)  : 1;
  localparam int DIGW = (NDIG   > 1) ? $clog2(NDIG)   : 1;
  localparam int FRW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [NDIG-1:0] DIG_ONE = NDIG'(1);

  logic [1:0]        state, nxt_state;
  logic [WW-1:0]     dwell_cnt, nxt_dwell;
  logic [DIGW-1:0]   dig_cnt, nxt_dig;
  logic [FRW-1:0]    frame_cnt, nxt_frame;
  logic [4*NDIG-1:0] shadow, nxt_shadow;
  logic [3:0]        nxt_nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = ESEG;
    endcase
  endfunction

  // Next-state and next-position logic; outputs are registered from these values
  // so the display matches the position the counters will hold next cycle.
  always_comb begin
    nxt_state  = state;
    nxt_dwell  = dwell_cnt;
    nxt_dig    = dig_cnt;
    nxt_frame  = frame_cnt;
    nxt_shadow = shadow;
    case (state)
      S_IDLE: begin
        if (req) begin
          nxt_state  = S_SCAN;
          nxt_shadow = data_in;
          nxt_dwell  = '0;
          nxt_dig    = '0;
          nxt_frame  = '0;
        end
      end
      S_SCAN: begin
        if (dwell_cnt == WW'(DWELL - 1)) begin
          nxt_dwell = '0;
          if (dig_cnt == DIGW'(NDIG - 1)) begin
            nxt_dig = '0;
            if (frame_cnt == FRW'(FRAMES - 1)) begin
              nxt_state = S_DONE;
              nxt_frame = '0;
            end else begin
              nxt_frame = frame_cnt + FRW'(1);
            end
          end else begin
            nxt_dig = dig_cnt + DIGW'(1);
          end
        end else begin
          nxt_dwell = dwell_cnt + WW'(1);
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  assign nxt_nib = nxt_shadow[4*nxt_dig +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      dwell_cnt <= '0;
      dig_cnt   <= '0;
      frame_cnt <= '0;
      shadow    <= '0;
      ack       <= 1'b0;
      done_p    <= 1'b0;
      mode      <= MODE_DONE;
      seg       <= '0;
      dig_en    <= '0;
    end else begin
      state     <= nxt_state;
      dwell_cnt <= nxt_dwell;
      dig_cnt   <= nxt_dig;
      frame_cnt <= nxt_frame;
      shadow    <= nxt_shadow;
      ack       <= (state == S_IDLE) && req;
      done_p    <= (nxt_state == S_DONE);
      mode      <= (nxt_state == S_SCAN) ? MODE_START : MODE_DONE;
      seg       <= (nxt_state == S_SCAN) ? decode(nxt_nib) : 7'b0;
      dig_en    <= (nxt_state == S_SCAN) ? (DIG_ONE << nxt_dig) : '0;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4, the number of multiplexed 7-segment digits.
REQ-002 SHALL have parameter DWELL, default 4, the clock cycles each digit is driven; legal range >= 1.
REQ-003 SHALL have parameter FRAMES, default 2, the full scans per request; legal range >= 1.
REQ-004 SHALL have parameter ESEG, default 7'b1111100, the error/fill segment pattern.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port req, input, 1 bit: display request; the requester holds it until ack.
REQ-008 SHALL have port data_in, input, 4*NDIG bits: hex nibbles; digit i = data_in[4i+3:4i].
REQ-009 SHALL have port ack, output, 1 bit: one-cycle pulse when the request is accepted.
REQ-010 SHALL have port mode, output, mode_t: start while scanning, done otherwise.
REQ-011 SHALL have port done_p, output, 1 bit: one-cycle pulse at the end of a request.
REQ-012 SHALL have port seg, output, 7 bits: segments {a,b,c,d,e,f,g}, with bit 6 = a, active-high.
REQ-013 SHALL have port dig_en, output, NDIG bits: one-hot digit enable, active-high.

Function
REQ-014 SHALL implement an FSM with states IDLE, SCAN and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, req=1 at a rising edge SHALL:
- capture data_in into a shadow register;
- set ack=1 for exactly the next cycle;
- enter SCAN with digit 0 displayed from that next cycle.
REQ-016 In SCAN, each digit i SHALL be shown for DWELL consecutive cycles: dig_en = 1<<i, seg = decode(shadow nibble i).
REQ-017 Digit order SHALL be 0..NDIG-1, then wrap to 0; a frame counter SHALL increment at each wrap.
REQ-018 After FRAMES complete frames (NDIG*DWELL*FRAMES SCAN cycles in total), the FSM SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-019 In DONE: done_p=1, seg=0, dig_en=0; done_p SHALL be 0 in all other states.
REQ-020 mode SHALL be start in SCAN and done in IDLE and DONE.
REQ-021 In IDLE: seg=0, dig_en=0, ack=0.
REQ-022 Decode for nibbles 0-9 SHALL use the standard patterns (0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011).
REQ-023 Decode for nibbles 10-15 SHALL output ESEG.
REQ-024 req during SCAN or DONE SHALL be ignored: no ack, no shadow update; a held req SHALL be accepted on the first IDLE cycle.
REQ-025 Changes on data_in after acceptance SHALL NOT affect the displayed values until the next accepted request.
REQ-026 Counters SHALL be sized $clog2 of their range (minimum 1 bit) and SHALL wrap without overflow into other fields.
REQ-027 dig_en SHALL never have more than one bit set in any cycle.

Reset
REQ-028 rst=1 SHALL asynchronously force the following, regardless of current state including mid-SCAN:
- state=IDLE;
- ack=0, done_p=0, seg=0, dig_en=0, mode=done;
- all counters and the shadow register to 0.
REQ-029 On rst deassertion the block SHALL accept a req at the first following rising edge.

Verification
REQ-030 (DWELL=2, FRAMES=1) req with data_in=16'h1234 -> ack pulse, then each for 2 cycles:
- dig_en=0001, seg=0110011;
- dig_en=0010, seg=1111001;
- dig_en=0100, seg=1101101;
- dig_en=1000, seg=0110000;
then one done_p cycle, then IDLE.
REQ-031 data_in=16'hF0A9 -> digit 1 and digit 3 show ESEG; digit 0 shows 1111011; digit 2 shows 1111110.
REQ-032 req held high continuously -> ack pulses separated by exactly NDIG*DWELL*FRAMES+2 cycles; no ack during SCAN or DONE.
REQ-033 Change data_in during SCAN -> displayed segments unchanged for the remainder of the request.
REQ-034 Assert rst in the middle of digit 2 of frame 1 -> same cycle, seg=0, dig_en=0, mode=done; the next req restarts at digit 0, frame 0.
REQ-035 FRAMES=2, DWELL=1 -> exactly 8 SCAN cycles, mode=start throughout, and a single done_p pulse.
